// File: rtl/sync_fifo_pkg.sv
// Shared types, default parameters and sizing helpers for param_sync_fifo and its bench.
package sync_fifo_pkg;

  localparam int DEF_WIDTH    = 8;
  localparam int DEF_DEPTH    = 16;
  localparam int DEF_AF_LEVEL = 12;
  localparam int DEF_AE_LEVEL = 4;

  typedef struct packed {
    logic overflow;
    logic underflow;
  } fifo_err_t;

  // The occupancy counter has to represent DEPTH itself, not just DEPTH-1.
  function automatic int clog2_cnt(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Simple dual-port storage for param_sync_fifo: synchronous write port, with a registered
// read port by default or a combinational read port when SYNC_FIFO_FWFT_EN is defined.
module sync_fifo_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Head word is presented directly; rst and re have no role in this mode.
  logic unused_rd;
  assign unused_rd = ^{rst, re};
  assign rdata     = mem[raddr];
`else
  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end
`endif

endmodule

// File: rtl/param_sync_fifo.sv
// Parametrised single-clock FIFO with handshake, level flags and error pulses.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is 1-cycle read latency.
module param_sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AF_LEVEL = DEF_AF_LEVEL,
  parameter int AE_LEVEL = DEF_AE_LEVEL,
  localparam int CW      = clog2_cnt(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
    $error("param_sync_fifo: DEPTH must be a power of 2 and >= 2");
  end
  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_af_chk
    $error("param_sync_fifo: AF_LEVEL must be in 1..DEPTH");
  end
  if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_ae_chk
    $error("param_sync_fifo: AE_LEVEL must be in 0..DEPTH-1");
  end

  logic [PW-1:0] wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
  logic [CW-1:0] count_n;
  logic          wr_acc, rd_acc;
  fifo_err_t     err_q, err_n;

  // Acceptance and error decisions look only at the registered (pre-edge) flags.
  always_comb begin
    wr_acc          = wr_en & ~full;
    rd_acc          = rd_en & ~empty;
    wr_ptr_n        = wr_ptr + PW'(wr_acc);
    rd_ptr_n        = rd_ptr + PW'(rd_acc);
    count_n         = count + CW'(wr_acc) - CW'(rd_acc);
    err_n.overflow  = wr_en & full;
    err_n.underflow = rd_en & empty;
  end

  // Pointer/flag register stage; the pointer MSB is the lap bit that separates full from empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      err_q        <= '0;
    end else begin
      wr_ptr       <= wr_ptr_n;
      rd_ptr       <= rd_ptr_n;
      count        <= count_n;
      full         <= (wr_ptr_n[AW-1:0] == rd_ptr_n[AW-1:0]) && (wr_ptr_n[AW] != rd_ptr_n[AW]);
      empty        <= (wr_ptr_n == rd_ptr_n);
      almost_full  <= (count_n >= CW'(AF_LEVEL));
      almost_empty <= (count_n <= CW'(AE_LEVEL));
      err_q        <= err_n;
    end
  end

  assign overflow  = err_q.overflow;
  assign underflow = err_q.underflow;

  sync_fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_acc & ~rst),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (wr_data),
    .re    (rd_acc & ~rst),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (rd_data)
  );

`ifdef SYNC_FIFO_FWFT_EN
  assign rd_valid = ~empty;
`else
  // Read-valid stage, aligned with the registered RAM output.
  always_ff @(posedge clk) begin
    if (rst) rd_valid <= 1'b0;
    else     rd_valid <= rd_acc;
  end
`endif

endmodule
